// File: rtl/plcounter_wrap_monitor.sv
// plcounter_wrap_monitor
//   Watches the output of a parallel-load up/down counter, detects wrap-around,
//   extends the count with a wrap counter and raises a sticky compare-match flag.
//   All outputs are registered: the value sampled at an edge is visible right after it.
//   Optional build macro: PLCNT_MON_DELTA_CHK_EN enables the sticky step/delta error
//   check on err. When the macro is absent, err is tied to 0.
module plcounter_wrap_monitor #(
  parameter int WIDTH     = 8,
  parameter int EXT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       updown,
  input  logic [WIDTH-1:0]           cnt,
  input  logic                       cnt_load,
  input  logic [WIDTH+EXT_WIDTH-1:0] cmp_val,
  input  logic                       cmp_we,
  input  logic                       match_clr,
  output logic [WIDTH+EXT_WIDTH-1:0] ext_cnt,
  output logic                       wrap_up,
  output logic                       wrap_dn,
  output logic                       match,
  output logic                       ovf,
  output logic                       err
);

  localparam logic [WIDTH-1:0]     CNT_ONES = '1;
  localparam logic [EXT_WIDTH-1:0] EXT_ONES = '1;
  localparam logic [EXT_WIDTH-1:0] EXT_ONE  = EXT_WIDTH'(1);

  logic [WIDTH-1:0]           cnt_q;
  logic                       prev_vld_q;
  logic [EXT_WIDTH-1:0]       wrap_cnt_q, wrap_cnt_d;
  logic [WIDTH+EXT_WIDTH-1:0] ext_cnt_q, ext_cnt_d;
  logic [WIDTH+EXT_WIDTH-1:0] cmp_q;
  logic                       wrap_up_q, wrap_dn_q;
  logic                       match_q, match_d;
  logic                       ovf_q, ovf_d;
  logic                       up_wrap, dn_wrap;

  // Wrap detection, wrap counter, extended count and sticky flag next-state logic.
  always_comb begin
    up_wrap    = 1'b0;
    dn_wrap    = 1'b0;
    wrap_cnt_d = wrap_cnt_q;
    ovf_d      = ovf_q;
    match_d    = match_q;

    // A wrap is only meaningful against a valid previous sample and no load.
    if (prev_vld_q && !cnt_load) begin
      up_wrap = updown && (cnt_q == CNT_ONES) && (cnt == '0);
      dn_wrap = !updown && (cnt_q == '0) && (cnt == CNT_ONES);
    end

    if (cnt_load) begin
      // Load is a discontinuity: restart the extension and drop overflow history.
      wrap_cnt_d = '0;
      ovf_d      = 1'b0;
    end else if (up_wrap) begin
      wrap_cnt_d = wrap_cnt_q + EXT_ONE;
      if (wrap_cnt_q == EXT_ONES) ovf_d = 1'b1;
    end else if (dn_wrap) begin
      wrap_cnt_d = wrap_cnt_q - EXT_ONE;
      if (wrap_cnt_q == '0) ovf_d = 1'b1;
    end

    ext_cnt_d = {wrap_cnt_d, cnt};

    // Compare uses the current compare register; a new match beats a clear.
    if (ext_cnt_d == cmp_q) begin
      match_d = 1'b1;
    end else if (match_clr) begin
      match_d = 1'b0;
    end
  end

  // Sample history, extended count, pulses and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      prev_vld_q <= 1'b0;
      wrap_cnt_q <= '0;
      ext_cnt_q  <= '0;
      wrap_up_q  <= 1'b0;
      wrap_dn_q  <= 1'b0;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt;
      prev_vld_q <= 1'b1;
      wrap_cnt_q <= wrap_cnt_d;
      ext_cnt_q  <= ext_cnt_d;
      wrap_up_q  <= up_wrap;
      wrap_dn_q  <= dn_wrap;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
    end
  end

  // Compare register; a write takes effect for the compare of the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_q <= '1;
    end else if (cmp_we) begin
      cmp_q <= cmp_val;
    end
  end

`ifdef PLCNT_MON_DELTA_CHK_EN
  logic [WIDTH-1:0] delta;
  logic             delta_ok;
  logic             err_q, err_d;

  // Legal steps are hold, or one step in the current direction (modulo 2^WIDTH).
  always_comb begin
    delta    = cnt - cnt_q;
    delta_ok = (delta == '0) || (updown ? (delta == WIDTH'(1)) : (delta == CNT_ONES));
    err_d    = err_q;
    if (cnt_load) begin
      err_d = 1'b0;
    end else if (prev_vld_q && !delta_ok) begin
      err_d = 1'b1;
    end
  end

  // Sticky delta error, cleared by reset or a counter load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign ext_cnt = ext_cnt_q;
  assign wrap_up = wrap_up_q;
  assign wrap_dn = wrap_dn_q;
  assign match   = match_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_plcounter_wrap_monitor.sv
// Directed testbench for plcounter_wrap_monitor (WIDTH=8, EXT_WIDTH=8).
// Expected err values follow PLCNT_MON_DELTA_CHK_EN when it is defined for the build.
module tb_plcounter_wrap_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        updown;
  logic [7:0]  cnt;
  logic        cnt_load;
  logic [15:0] cmp_val;
  logic        cmp_we;
  logic        match_clr;
  logic [15:0] ext_cnt;
  logic        wrap_up, wrap_dn, match, ovf, err;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef PLCNT_MON_DELTA_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        up;
    logic [7:0]  cnt;
    logic        load;
    logic [15:0] cmp_val;
    logic        cmp_we;
    logic        clr;
    logic [15:0] ext;
    logic        wu, wd, m, ov, er;
  } vec_t;

  plcounter_wrap_monitor #(.WIDTH(8), .EXT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .updown(updown), .cnt(cnt), .cnt_load(cnt_load),
    .cmp_val(cmp_val), .cmp_we(cmp_we), .match_clr(match_clr),
    .ext_cnt(ext_cnt), .wrap_up(wrap_up), .wrap_dn(wrap_dn),
    .match(match), .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic up, logic [7:0] c, logic ld, logic [15:0] cv, logic we,
                              logic cl, logic [15:0] ext, logic wu, logic wd, logic m,
                              logic ov, logic er_on);
    vec_t v;
    v.up = up; v.cnt = c; v.load = ld; v.cmp_val = cv; v.cmp_we = we; v.clr = cl;
    v.ext = ext; v.wu = wu; v.wd = wd; v.m = m; v.ov = ov; v.er = er_on & CHK;
    return v;
  endfunction

  task automatic check(string name, logic [20:0] act, logic [20:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {ext,wu,wd,m,ovf,err}=%h/%b%b%b%b%b required %h/%b%b%b%b%b",
               name, act[20:5], act[4], act[3], act[2], act[1], act[0],
               exp[20:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: ext=%h wu=%b wd=%b m=%b ovf=%b err=%b",
               name, act[20:5], act[4], act[3], act[2], act[1], act[0]);
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare 1 time unit after the edge.
  task automatic apply(vec_t v, string name);
    updown = v.up; cnt = v.cnt; cnt_load = v.load;
    cmp_val = v.cmp_val; cmp_we = v.cmp_we; match_clr = v.clr;
    @(posedge clk);
    #1;
    check(name, {ext_cnt, wrap_up, wrap_dn, match, ovf, err},
          {v.ext, v.wu, v.wd, v.m, v.ov, v.er});
  endtask

  vec_t vecs[20];

  initial begin
    //            up cnt   ld cmp_val we  clr ext      wu wd m  ov er
    vecs[0]  = mk(1, 8'hFD, 1, 16'h0, 0, 0, 16'h00FD, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 8'hFE, 0, 16'h0, 0, 0, 16'h00FE, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 8'hFF, 0, 16'h0, 0, 0, 16'h00FF, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 8'h00, 0, 16'h0, 0, 0, 16'h0100, 1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 8'hFF, 0, 16'h0, 0, 0, 16'h00FF, 0, 1, 0, 0, 0);
    vecs[5]  = mk(1, 8'hFF, 0, 16'h0102, 1, 0, 16'h00FF, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 8'h00, 0, 16'h0, 0, 0, 16'h0100, 1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 8'h01, 0, 16'h0, 0, 0, 16'h0101, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 8'h02, 0, 16'h0, 0, 0, 16'h0102, 0, 0, 1, 0, 0);
    vecs[9]  = mk(1, 8'h03, 0, 16'h0, 0, 0, 16'h0103, 0, 0, 1, 0, 0);
    vecs[10] = mk(0, 8'h02, 0, 16'h0, 0, 1, 16'h0102, 0, 0, 1, 0, 0);
    vecs[11] = mk(1, 8'h03, 0, 16'h0, 0, 1, 16'h0103, 0, 0, 0, 0, 0);
    vecs[12] = mk(1, 8'h03, 0, 16'h0, 0, 0, 16'h0103, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 8'h00, 1, 16'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 8'hFF, 0, 16'h0, 0, 0, 16'hFFFF, 0, 1, 0, 1, 0);
    vecs[15] = mk(1, 8'h10, 1, 16'h0, 0, 0, 16'h0010, 0, 0, 0, 0, 0);
    vecs[16] = mk(1, 8'h14, 0, 16'h0, 0, 0, 16'h0014, 0, 0, 0, 0, 1);
    vecs[17] = mk(1, 8'h15, 0, 16'h0, 0, 0, 16'h0015, 0, 0, 0, 0, 1);
    vecs[18] = mk(1, 8'h15, 1, 16'h0, 0, 0, 16'h0015, 0, 0, 0, 0, 0);
    vecs[19] = mk(0, 8'h14, 0, 16'h0, 0, 0, 16'h0014, 0, 0, 0, 0, 0);

    rst = 1'b1; updown = 1'b1; cnt = 8'h00; cnt_load = 1'b0;
    cmp_val = 16'h0; cmp_we = 1'b0; match_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {ext_cnt, wrap_up, wrap_dn, match, ovf, err}, 21'h0);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Drive the wrap counter to 0xFF through 255 up wraps (jumping back to 0xFF each time).
    for (int k = 1; k <= 255; k++) begin
      apply(mk(1, 8'hFF, 0, 16'h0, 0, 0, {8'(k - 1), 8'hFF}, 0, 0, 0, 0, 1), $sformatf("jump%0d", k));
      apply(mk(1, 8'h00, 0, 16'h0, 0, 0, {8'(k), 8'h00}, 1, 0, 0, 0, 1), $sformatf("wrap%0d", k));
    end
    apply(mk(1, 8'hFF, 0, 16'h0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 1), "pre_ovf");
    apply(mk(1, 8'h00, 0, 16'h0, 0, 0, 16'h0000, 1, 0, 0, 1, 1), "ovf_up_wrap");
    apply(mk(1, 8'h00, 0, 16'h0, 0, 0, 16'h0000, 0, 0, 0, 1, 1), "ovf_sticky");
    apply(mk(1, 8'h00, 1, 16'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 0), "ovf_load_clr");
    apply(mk(1, 8'h01, 0, 16'h0, 0, 0, 16'h0001, 0, 0, 0, 0, 0), "mid_count");

    // Asynchronous reset well away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {ext_cnt, wrap_up, wrap_dn, match, ovf, err}, 21'h0);
    @(posedge clk);
    #1;
    check("reset_hold", {ext_cnt, wrap_up, wrap_dn, match, ovf, err}, 21'h0);
    rst = 1'b0;

    // First sample after reset has no history: 0 -> FF must not count as a down wrap.
    apply(mk(0, 8'hFF, 0, 16'h0, 0, 0, 16'h00FF, 0, 0, 0, 0, 0), "post_rst_no_wrap");
    apply(mk(0, 8'h00, 0, 16'h0, 0, 0, 16'h0000, 0, 0, 0, 0, 1), "post_rst_jump");
    // Compare register back at its all-ones default: 0xFFFF matches.
    apply(mk(0, 8'hFF, 0, 16'h0, 0, 0, 16'hFFFF, 0, 1, 1, 1, 1), "default_cmp_match");
    apply(mk(0, 8'hFE, 0, 16'h0, 0, 1, 16'hFFFE, 0, 0, 0, 1, 1), "match_clr_lone");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

endmodule
